// File: rtl/seq_adder_n.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes SLICE bits per clock behind a start/busy/done handshake.
// Latency: NSTEP = WIDTH/SLICE cycles from the accepting edge to the done pulse. Throughput is one operation per NSTEP+1 cycles.
// Backpressure: start is sampled only while idle. A request made while busy is dropped, not queued.
module seq_adder_n #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTEP = WIDTH / SLICE;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  // Operand shift registers. The low SLICE bits always hold the slice being
  // summed this cycle. opb already holds ~b for subtraction, so every slice is a
  // plain addition.
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  // Sum slices enter at the top and move down. After NSTEP shifts the register
  // holds the whole result in order.
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] acc_next;
  logic             msb_cin;

  // Slice adder, result-register update and carry into the slice MSB
  always_comb begin
    slice_sum = {1'b0, opa[SLICE-1:0]} + {1'b0, opb[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
    acc_next  = (acc >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
    // The sum bit is a ^ b ^ carry_in, so the carry into this bit can be recovered from the bit itself.
    // Only the final slice uses this value. There, bit SLICE-1 is bit WIDTH-1 of the full result.
    msb_cin   = slice_sum[SLICE-1] ^ opa[SLICE-1] ^ opb[SLICE-1];
  end

  // Handshake FSM with datapath. All outputs are registered, and s, cout and ovf change only on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            // For subtraction, a - b - bin is computed as a + ~b + (1 - bin).
            carry <= cin ^ sub;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> SLICE;
          opb   <= opb >> SLICE;
          carry <= slice_sum[SLICE];
          acc   <= acc_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            s     <= acc_next;
            cout  <= slice_sum[SLICE];
            ovf   <= msb_cin ^ slice_sum[SLICE];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder_n.sv
// Bench for seq_adder_n: one instance with WIDTH=8/SLICE=1 and one with WIDTH=8/SLICE=4.
// Expected results are queued when a request is driven and compared when done pulses.
// Inputs are driven and outputs sampled on the falling edge. The DUT uses the rising edge.
module tb_seq_adder_n;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } res_t;

  logic       clk;
  logic       reset;

  logic       start1, cin1, sub1, busy1, done1, cout1, ovf1;
  logic [7:0] a1, b1, s1;
  logic       start4, cin4, sub4, busy4, done4, cout4, ovf4;
  logic [7:0] a4, b4, s4;

  res_t q1[$];
  res_t q4[$];

  int checks = 0;
  int errors = 0;

  seq_adder_n #(.WIDTH(8), .SLICE(1)) u_ser (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
  );

  seq_adder_n #(.WIDTH(8), .SLICE(4)) u_nib (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: full 9-bit sum, with signed overflow taken from the operand and result signs.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    res_t       r;
    logic [7:0] bb;
    logic [8:0] t;
    bb     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + {8'd0, cin ^ sub};
    r.s    = t[7:0];
    r.cout = t[8];
    r.ovf  = (a[7] == bb[7]) && (t[7] != a[7]);
    return r;
  endfunction

  // Drive one request on the serial instance and queue its expected result. Returns just after the accepting edge.
  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub, input res_t exp);
    a1 = a; b1 = b; cin1 = cin; sub1 = sub; start1 = 1'b1;
    q1.push_back(exp);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Wait for a done pulse on the serial instance, with a cycle bound.
  task automatic wait_done1(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done1 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, done1, s1, cout1, ovf1} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ser: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0", busy1, done1, s1, cout1, ovf1);
    end
    checks++;
    if ({busy4, done4, s4, cout4, ovf4} !== 12'h000) begin
      errors++;
      $display("FAIL reset_nib: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0", busy4, done4, s4, cout4, ovf4);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int   lat, nbusy;
    bit   seen;
    res_t r;
    issue1(8'h01, 8'h01, 1'b0, 1'b0, '{s: 8'h02, cout: 1'b0, ovf: 1'b0});
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_after_accept: got %b, want 1", busy1);
    end
    nbusy = 1;
    lat   = 0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done1 === 1'b1) seen = 1'b1;
      else if (busy1 === 1'b1) nbusy++;
    end
    checks++;
    if (!seen || lat != 8) begin
      errors++;
      $display("FAIL basic_latency: got done seen=%0d after %0d cycles, want 8", seen, lat);
    end
    checks++;
    if (nbusy != 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", nbusy);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %b, want 0", busy1);
    end
    r = q1.pop_front();
    checks++;
    if ({s1, cout1, ovf1} !== {r.s, r.cout, r.ovf}) begin
      errors++;
      $display("FAIL basic_result: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", s1, cout1, ovf1, r.s, r.cout, r.ovf);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: done still %b one cycle later, want 0", done1);
    end
  endtask

  // Directed add and subtract corner cases. Expected values are written out by hand.
  task automatic test_corners;
    logic [7:0] ta[7] = '{8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h05, 8'h80, 8'h10};
    logic [7:0] tb[7] = '{8'h01, 8'h01, 8'h80, 8'hFF, 8'h07, 8'h01, 8'h00};
    logic       tc[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       tsb[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    res_t       te[7] = '{'{8'h00, 1'b1, 1'b0}, '{8'h80, 1'b0, 1'b1}, '{8'h00, 1'b1, 1'b1},
                          '{8'hFF, 1'b1, 1'b0}, '{8'hFE, 1'b0, 1'b0}, '{8'h7F, 1'b1, 1'b1},
                          '{8'h0F, 1'b1, 1'b0}};
    int   lat;
    bit   seen;
    res_t r;
    for (int k = 0; k < 7; k++) begin
      issue1(ta[k], tb[k], tc[k], tsb[k], te[k]);
      wait_done1(lat, seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL corner_%0d_timeout: no done within 40 cycles", k);
        q1.delete();
      end else begin
        r = q1.pop_front();
        if ({s1, cout1, ovf1} !== {r.s, r.cout, r.ovf}) begin
          errors++;
          $display("FAIL corner_%0d (a=%h b=%h cin=%b sub=%b): got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b",
                   k, ta[k], tb[k], tc[k], tsb[k], s1, cout1, ovf1, r.s, r.cout, r.ovf);
        end
      end
    end
  endtask

  // While busy, start toggles and the inputs change every cycle. Only the first operation may complete.
  task automatic test_handshake;
    int   ndone;
    res_t r;
    issue1(8'h3C, 8'h15, 1'b1, 1'b0, '{s: 8'h52, cout: 1'b0, ovf: 1'b0});
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy1 === 1'b1) begin
        start1 = ~start1;
        a1 = 8'($urandom); b1 = 8'($urandom);
        cin1 = 1'($urandom); sub1 = 1'($urandom);
      end else begin
        start1 = 1'b0;
      end
      @(negedge clk);
      if (done1 === 1'b1) begin
        ndone++;
        start1 = 1'b0;
        if (q1.size() > 0) begin
          r = q1.pop_front();
          checks++;
          if ({s1, cout1, ovf1} !== {r.s, r.cout, r.ovf}) begin
            errors++;
            $display("FAIL handshake_result: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", s1, cout1, ovf1, r.s, r.cout, r.ovf);
          end
        end
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL handshake_done_count: got %0d, want 1", ndone);
    end
    q1.delete();
  endtask

  // start held high through the done cycle: the second request is accepted at E9.
  task automatic test_back_to_back;
    int   lat;
    bit   seen;
    res_t r;
    a1 = 8'h0F; b1 = 8'h01; cin1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
    q1.push_back('{s: 8'h10, cout: 1'b0, ovf: 1'b0});
    @(negedge clk);
    wait_done1(lat, seen);
    checks++;
    if (!seen || lat != 8) begin
      errors++;
      $display("FAIL b2b_first_latency: seen=%0d after %0d cycles, want 8", seen, lat);
    end
    r = q1.pop_front();
    checks++;
    if ({s1, cout1, ovf1} !== {r.s, r.cout, r.ovf}) begin
      errors++;
      $display("FAIL b2b_first_result: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", s1, cout1, ovf1, r.s, r.cout, r.ovf);
    end
    a1 = 8'h20; b1 = 8'h22; cin1 = 1'b0; sub1 = 1'b1;
    q1.push_back('{s: 8'hFE, cout: 1'b0, ovf: 1'b0});
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept_e9: got busy=%b done=%b, want busy=1 done=0", busy1, done1);
    end
    wait_done1(lat, seen);
    checks++;
    if (!seen || lat != 8) begin
      errors++;
      $display("FAIL b2b_second_latency: seen=%0d after %0d cycles, want 8", seen, lat);
      q1.delete();
    end else begin
      r = q1.pop_front();
      if ({s1, cout1, ovf1} !== {r.s, r.cout, r.ovf}) begin
        errors++;
        $display("FAIL b2b_second_result: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", s1, cout1, ovf1, r.s, r.cout, r.ovf);
      end
    end
  endtask

  task automatic test_reset_mid;
    int   ndone, lat;
    bit   seen;
    res_t r;
    issue1(8'h55, 8'h22, 1'b0, 1'b0, '{s: 8'h77, cout: 1'b0, ovf: 1'b0});
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy1, done1, s1, cout1, ovf1} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_async: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0", busy1, done1, s1, cout1, ovf1);
    end
    q1.delete();
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", ndone);
    end
    issue1(8'h03, 8'h04, 1'b0, 1'b0, '{s: 8'h07, cout: 1'b0, ovf: 1'b0});
    wait_done1(lat, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_next_timeout: no done within 40 cycles");
      q1.delete();
    end else begin
      r = q1.pop_front();
      if ({s1, cout1, ovf1} !== {r.s, r.cout, r.ovf}) begin
        errors++;
        $display("FAIL reset_mid_next_result: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b", s1, cout1, ovf1, r.s, r.cout, r.ovf);
      end
    end
  endtask

  // SLICE=4 instance: every a value against a mix of fixed and random b values, for all sub/cin modes.
  task automatic test_sweep_nibble;
    logic [7:0] bv;
    res_t       r;
    for (int m = 0; m < 4; m++) begin
      for (int av = 0; av < 256; av++) begin
        for (int k = 0; k < 16; k++) begin
          case (k)
            0: bv = 8'h00;
            1: bv = 8'h01;
            2: bv = 8'h7F;
            3: bv = 8'h80;
            4: bv = 8'hFF;
            5: bv = 8'hFE;
            6: bv = 8'(av);
            7: bv = ~8'(av);
            default: bv = 8'($urandom);
          endcase
          a4 = 8'(av); b4 = bv; sub4 = m[1]; cin4 = m[0]; start4 = 1'b1;
          q4.push_back(model(a4, b4, cin4, sub4));
          @(negedge clk);
          start4 = 1'b0;
          @(negedge clk);
          @(negedge clk);
          r = q4.pop_front();
          checks++;
          if ({done4, s4, cout4, ovf4} !== {1'b1, r.s, r.cout, r.ovf}) begin
            errors++;
            $display("FAIL nibble a=%h b=%h sub=%b cin=%b: got done=%b s=%h cout=%b ovf=%b, want done=1 s=%h cout=%b ovf=%b",
                     a4, b4, sub4, cin4, done4, s4, cout4, ovf4, r.s, r.cout, r.ovf);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_sweep_nibble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
